// File: rtl/clk_rate_pkg.sv
// Shared definitions for the game-speed rate generator and the level-indexed rate selector.
package clk_rate_pkg;
  localparam int                 LEVEL_W   = 2;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 2'd3;
  localparam int                 PHASE_W   = 4;

  // Level encoding seen by the rate selector: slowest rate first.
  typedef enum logic [LEVEL_W-1:0] {
    LVL_CL1 = 2'd0,
    LVL_CL2 = 2'd1,
    LVL_CL3 = 2'd2,
    LVL_CL4 = 2'd3
  } rate_level_e;

  function automatic rate_level_e level_inc(input rate_level_e l);
    return (l == LEVEL_MAX) ? l : rate_level_e'(l + 2'd1);
  endfunction
endpackage

// File: rtl/clk_rate_gen_tick_prescaler.sv
// Divides the system clock by PRESCALE and flags the last enabled cycle of each period.
module tick_prescaler #(
  parameter int PRESCALE = 3_125_000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_en,
  input  logic i_clear,
  output logic o_base_tick
);
  localparam int CNT_W = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap      = i_en && (r_cnt == CNT_LAST);
  assign o_base_tick = w_wrap;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset)     r_cnt <= '0;
    else if (i_clear) r_cnt <= '0;
    else if (i_en)    r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
  end
endmodule

// File: rtl/clk_rate_gen.sv
// Four binary-weighted game-speed square waves, their rising-edge tick pulses and the difficulty level.
module clk_rate_gen
  import clk_rate_pkg::*;
#(
  parameter int PRESCALE = 3_125_000
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_en,
  input  logic               i_clear,
  input  logic               i_level_up,
  output logic [LEVEL_W-1:0] o_level,
  output logic               o_CL1,
  output logic               o_CL2,
  output logic               o_CL3,
  output logic               o_CL4,
  output logic [3:0]         o_tick
);
  logic               w_base_tick;
  logic [PHASE_W-1:0] r_phase;
  logic [PHASE_W-1:0] w_phase_nxt;
  logic [PHASE_W-1:0] w_rise;
  logic [3:0]         w_tick_nxt;
  logic [3:0]         r_tick;
  rate_level_e        r_level;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_en        (i_en),
    .i_clear     (i_clear),
    .o_base_tick (w_base_tick)
  );

  assign w_phase_nxt = r_phase + PHASE_W'(1);
  assign w_rise      = ~r_phase & w_phase_nxt;

  // tick[0] follows CL1 (phase MSB), tick[3] follows CL4 (phase LSB).
  always_comb begin
    w_tick_nxt = '0;
    for (int k = 0; k < 4; k++) w_tick_nxt[k] = w_base_tick & w_rise[3-k];
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_phase <= '0;
      r_tick  <= '0;
      r_level <= LVL_CL1;
    end else if (i_clear) begin
      r_phase <= '0;
      r_tick  <= '0;
      r_level <= LVL_CL1;
    end else begin
      if (w_base_tick) r_phase <= w_phase_nxt;
      r_tick <= w_tick_nxt;
      if (i_level_up) r_level <= level_inc(r_level);
    end
  end

  assign o_level = r_level;
  assign o_CL4   = r_phase[0];
  assign o_CL3   = r_phase[1];
  assign o_CL2   = r_phase[2];
  assign o_CL1   = r_phase[3];
  assign o_tick  = r_tick;
endmodule

// File: doc/clk_rate_gen.md
# clk_rate_gen

Generates the four game-speed rate signals CL1..CL4 (slowest to fastest) from the system clock, and keeps the current difficulty level that picks among them. It feeds the level-indexed 4:1 rate selector that produces CLKHZ for the sequence-display logic. It also provides synchronous one-cycle tick pulses, so clocked consumers can use clock enables instead of derived clocks.

## Interface
- PRESCALE, default 3_125_000: system-clock cycles per base tick; must be ≥ 2 (with a 50 MHz clock this gives CL4 = 8 Hz, CL1 = 1 Hz).
- clock  in  1  system clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  count enable; when low, prescaler and phase counter hold.
- clear  in  1  synchronous restart: zeroes prescaler, phase and level.
- level_up  in  1  one-cycle pulse that advances the level (saturating).
- level  out  2  current level, 0..3; drives the selector's level input.
- CL1, CL2, CL3, CL4  out  1 each  50 % duty square waves; periods 16P, 8P, 4P, 2P cycles (P = PRESCALE).
- tick  out  4  tick[0..3] is a one-cycle pulse on the rising edge of CL1..CL4.

## Operation
- Prescaler counts 0..PRESCALE-1 while en=1. At PRESCALE-1 it wraps to 0 and emits an internal base tick, which is combinational and not a port.
- On each base tick, the 4-bit phase counter increments and wraps 15→0.
- Bit mapping: CL4 = phase[0], CL3 = phase[1], CL2 = phase[2], CL1 = phase[3]. All four are driven directly from flops, so they are glitch-free.
- tick[k] is registered. It is 1 in the cycle after the edge where the mapped phase bit went 0→1, so it is high in the same cycle that CLk first reads 1. Otherwise it is 0.
- Level register:
  - level_up=1 with level<3: level increments.
  - level_up=1 with level=3: level stays at 3 (saturates).
- Priority (highest first): reset, then clear, then en / level_up.
- clear=1:
  - Next edge: prescaler=0, phase=0, level=0, tick=0.
  - en and level_up are ignored in that cycle.
- en=0:
  - Counters and CLx hold their values.
  - tick forces to 0.
  - level_up still works.
- en and level_up are independent and may be asserted in the same cycle.

## Timing
- Reset (async assert, deassert synchronized externally): prescaler=0, phase=0, level=0, CL1..CL4=0, tick=0.
- First CL4 rise comes PRESCALE cycles after the first enabled edge. CL4 toggles every PRESCALE enabled cycles.
- Phase wrap 15→0: CL1..CL4 all fall together, and no tick is emitted. At phase 0→1 only CL4 rises.
- Phase 7→8: CL1 rises and CL2..CL4 fall; tick = 4'b0001 for one cycle.
- level changes on the edge after level_up is sampled (latency 1). CLx phase is not disturbed by a level change.
- clear held for several cycles: all state stays 0. Counting restarts on the first edge with clear=0 and en=1.
- Reset asserted mid-count: all outputs go to reset values immediately, with no clock edge needed.

## Structure
- Shared package (clk_rate_pkg):
  - LEVEL_W = 2.
  - LEVEL_MAX = 2'd3.
  - PHASE_W = 4.
  - The level encoding shared with the rate selector: 0 = CL1 … 3 = CL4.
- Sub-module tick_prescaler (parameter PRESCALE; ports clock, reset, en, clear, base_tick). Its counter width is $clog2(PRESCALE).
- The top level holds the phase counter, the edge-detect tick registers and the level register.

## Test plan
- Reset then PRESCALE=4, en=1:
  - CL4 first rises at cycle 4, then toggles every 4 cycles.
  - CL1 period is 64 cycles.
  - tick[3] is high one cycle on every CL4 rise.
- Run to phase 7→8 (cycle 32): CL1 rises, CL2..CL4 fall, tick=4'b0001. At cycle 64 all CLx fall and tick=0.
- Pulse level_up 5 times: level goes 1, 2, 3, 3, 3. Then clear=1 for 1 cycle: level=0, phase=0, CLx=0 on the next edge.
- en=0 for 10 cycles at phase 5: CLx frozen (CL4=1, CL3=0, CL2=1, CL1=0) and tick=0. After re-enable, counting resumes from the held prescaler value.
- clear and level_up in the same cycle: level=0 (clear wins). level_up and en in the same cycle: both take effect.
- Assert reset between clock edges mid-count: every output is 0 before the next edge. Counting restarts from 0 after release.
